// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state, mode encodings and counter sizing for serial_addsub
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple adder built from full-adder cells
module addsub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             cmsb
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/sub, CHUNK bits per clock; SERIAL_ADDSUB_SAT_EN enables signed saturation on overflow
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_w(N);
  if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
  end
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, ovf_q, in_ready_q, out_valid_q;
  logic [CHUNK-1:0] sum_d;
  logic             co_d, cmsb_d, last_d, ovf_d;
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_q[cnt_q*CHUNK +: CHUNK]),
    .y    (b_q[cnt_q*CHUNK +: CHUNK]),
    .ci   (c_q),
    .sum  (sum_d),
    .co   (co_d),
    .cmsb (cmsb_d)
  );
  // last-chunk detect; carry into vs out of the MSB differing is signed overflow
  always_comb begin
    last_d = cnt_q == CW'(N - 1);
    ovf_d  = co_d ^ cmsb_d;
  end
  // handshake FSM: latch operands with B' and carry-in pre-inverted for subtract, ripple one chunk per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= sub == MODE_ADD ? b : ~b;
          c_q        <= sub == MODE_SUB ? ~cin : cin;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          state_q    <= RUN;
        end
        RUN: begin
          s_q[cnt_q*CHUNK +: CHUNK] <= sum_d;
          c_q   <= co_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            cout_q      <= co_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SERIAL_ADDSUB_SAT_EN
            if (ovf_d) s_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and boundary-sweep checks of serial_addsub at WIDTH=8, CHUNK=2
module tb_serial_addsub;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0, s;
  logic       in_ready, out_valid, cout, ovf;
  int         total = 0, bad = 0;
  serial_addsub #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // reference: returns {ovf, cout, s}
  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic c, input logic m);
    logic [7:0] yb;
    logic [8:0] t;
    logic       o;
    yb = m ? ~y : y;
    t  = {1'b0, x} + {1'b0, yb} + {8'd0, m ? ~c : c};
    o  = (x[7] == yb[7]) && (t[7] != x[7]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (o) t[7:0] = x[7] ? 8'h80 : 8'h7F;
`endif
    return {o, t};
  endfunction
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts, input bit noise);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = noise;
    if (noise) begin a = 8'hAA; b = 8'h33; cin = ~tc; sub = ~ts; end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
  endtask
  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask
  task automatic expect_res(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    chk({tag, "_s"}, {24'd0, s}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask
  initial begin
    logic [7:0] vals [8];
    logic [9:0] r;
    vals = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    expect_res("rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd100, 8'd27, 1'b0, 1'b0, 1'b0);
    expect_res("add127", 8'd127, 1'b0, 1'b0);
    drain();
    issue(8'd100, 8'd28, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
    expect_res("add_ovf", 8'h7F, 1'b0, 1'b1);
`else
    expect_res("add_ovf", 8'h80, 1'b0, 1'b1);
`endif
    drain();
    issue(8'd5, 8'd7, 1'b0, 1'b1, 1'b0);
    expect_res("sub5_7", 8'hFE, 1'b0, 1'b0);
    drain();
    issue(8'd7, 8'd5, 1'b1, 1'b1, 1'b0);
    expect_res("sub7_5_b", 8'h01, 1'b1, 1'b0);
    drain();
    // 0x80 - 1 overflows negative-to-positive; noisy in_valid held through RUN and DONE
    issue(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
`ifdef SERIAL_ADDSUB_SAT_EN
      expect_res("bp", 8'h80, 1'b1, 1'b1);
`else
      expect_res("bp", 8'h7F, 1'b1, 1'b1);
`endif
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    drain();
    chk("post_drain_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    expect_res("after_abort", 8'h00, 1'b1, 1'b0);
    drain();
    foreach (vals[i]) foreach (vals[j]) for (int k = 0; k < 4; k++) begin
      r = ref_op(vals[i], vals[j], k[0], k[1]);
      issue(vals[i], vals[j], k[0], k[1], 1'b0);
      expect_res("sweep", r[7:0], r[8], r[9]);
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
